// File: rtl/sample_store_if.sv
// Bus bundle for sample_store: write stream, four read ports and chunker handshake.
interface sample_store_if #(
   parameter int unsigned DW = 32
);
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          clear;
   logic [31:0]   indx1;
   logic [31:0]   indx2;
   logic [31:0]   indx3;
   logic [31:0]   indx4;
   logic [DW-1:0] value1;
   logic [DW-1:0] value2;
   logic [DW-1:0] value3;
   logic [DW-1:0] value4;
   logic [3:0]    rd_err;
   logic          start;
   logic          done;
   logic          loaded;
   logic [31:0]   count;

   modport master (
      output wr_valid, wr_data, clear, indx1, indx2, indx3, indx4, done,
      input  wr_ready, value1, value2, value3, value4, rd_err, start, loaded, count
   );

   modport slave (
      input  wr_valid, wr_data, clear, indx1, indx2, indx3, indx4, done,
      output wr_ready, value1, value2, value3, value4, rd_err, start, loaded, count
   );
endinterface

// File: rtl/sample_store.sv
// Sliding window of NDATA samples with four registered logical-index read ports;
// logical index 0 is always the oldest sample held.
module sample_store #(
   parameter int unsigned NDATA = 20,
   parameter int unsigned DW    = 32,
   parameter bit          SLIDE = 1'b1
) (
   input logic           Clk,
   input logic           Rst,
   sample_store_if.slave bus
);
   localparam int unsigned AW = (NDATA > 1) ? $clog2(NDATA) : 1;
   localparam int unsigned CW = $clog2(NDATA + 1);
   localparam int unsigned NP = 4;

   typedef enum logic {LOAD = 1'b0, READY = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   base_q, base_d;
   logic [CW-1:0]   count_q, count_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;
   logic [DW-1:0]   mem_q [NDATA];
   logic [DW-1:0]   value_q [NP];
   logic [DW-1:0]   value_d [NP];
   logic [NP-1:0]   err_q, err_d;
   logic [31:0]     indx_c [NP];
   logic [AW:0]     sum_c [NP];
   logic [AW-1:0]   phys_c [NP];
   logic [AW-1:0]   wr_addr_c;
   logic            wr_ready_c;
   logic            loaded_c;
   logic            accept_c;

   assign indx_c[0] = bus.indx1;
   assign indx_c[1] = bus.indx2;
   assign indx_c[2] = bus.indx3;
   assign indx_c[3] = bus.indx4;

   // State register
   always_ff @(posedge Clk) begin
      if (!Rst) state_q <= LOAD;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = LOAD;
      end else begin
         case (state_q)
            LOAD:    if (accept_c && (count_q == CW'(NDATA - 1))) state_d = READY;
            READY:   state_d = READY;
            default: state_d = LOAD;
         endcase
      end
   end

   // FSM outputs; a full window only takes a sample between chunker runs
   always_comb begin
      wr_ready_c = 1'b0;
      loaded_c   = 1'b0;
      if (Rst && !bus.clear) begin
         wr_ready_c = (state_q == LOAD) ||
                      ((state_q == READY) && SLIDE && !busy_q && !start_q);
      end
      loaded_c = (state_q == READY);
   end

   assign accept_c  = bus.wr_valid && wr_ready_c;
   assign wr_addr_c = (state_q == LOAD) ? wptr_q : base_q;

   // Pointer, count and run-handshake updates
   always_comb begin
      wptr_d  = wptr_q;
      base_d  = base_q;
      count_d = count_q;
      start_d = 1'b0;
      busy_d  = busy_q;
      if (start_q)       busy_d = 1'b1;
      else if (bus.done) busy_d = 1'b0;
      if (bus.clear) begin
         wptr_d  = '0;
         base_d  = '0;
         count_d = '0;
         busy_d  = 1'b0;
      end else if (accept_c) begin
         if (state_q == LOAD) begin
            wptr_d  = (wptr_q == AW'(NDATA - 1)) ? '0 : wptr_q + AW'(1);
            count_d = count_q + CW'(1);
            start_d = (count_q == CW'(NDATA - 1));
         end else begin
            base_d  = (base_q == AW'(NDATA - 1)) ? '0 : base_q + AW'(1);
            start_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wptr_q  <= '0;
         base_q  <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         base_q  <= base_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         start_q <= start_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (accept_c) mem_q[wr_addr_c] <= bus.wr_data;
   end

   // Logical-to-physical read mapping; sum stays below 2*NDATA when in range
   always_comb begin
      for (int k = 0; k < NP; k++) begin
         sum_c[k]   = (AW+1)'(base_q) + (AW+1)'(indx_c[k][AW-1:0]);
         phys_c[k]  = (sum_c[k] >= (AW+1)'(NDATA)) ? AW'(sum_c[k] - (AW+1)'(NDATA))
                                                   : AW'(sum_c[k]);
         value_d[k] = '0;
         err_d[k]   = 1'b1;
         if (indx_c[k] < 32'(count_q)) begin
            value_d[k] = mem_q[phys_c[k]];
            err_d[k]   = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int k = 0; k < NP; k++) value_q[k] <= '0;
         err_q <= '0;
      end else begin
         for (int k = 0; k < NP; k++) value_q[k] <= value_d[k];
         err_q <= err_d;
      end
   end

   assign bus.wr_ready = wr_ready_c;
   assign bus.loaded   = loaded_c;
   assign bus.start    = start_q;
   assign bus.count    = 32'(count_q);
   assign bus.rd_err   = err_q;
   assign bus.value1   = value_q[0];
   assign bus.value2   = value_q[1];
   assign bus.value3   = value_q[2];
   assign bus.value4   = value_q[3];
endmodule

// File: doc/sample_store.md
# sample_store

Time-series sample buffer that answers the chunker's four parallel index/value read ports. Samples arrive on a valid/ready write stream and are held in a window of NDATA words. Once the window is full, the block pulses `start` to launch a chunker run. In sliding mode it then accepts one new sample per completed run, overwriting the oldest sample, so that logical index 0 is always the oldest sample.

## Interface
Parameters:
- NDATA, 20, window depth in samples; must be ≥ 2.
- DW, 32, sample width in bits.
- SLIDE, 1, 1 = accept new samples into a full window (sliding); 0 = window frozen until `clear`.

Ports:
- Clk  in  1  clock; all logic on posedge.
- Rst  in  1  reset, synchronous, active-low.
- wr_valid  in  1  write-stream sample valid.
- wr_data  in  DW  write-stream sample.
- wr_ready  out  1  store can accept a sample this cycle.
- clear  in  1  discard the window and restart loading.
- indx1..indx4  in  32 each  logical read index, 0 = oldest sample.
- value1..value4  out  DW each  registered read data.
- rd_err  out  4  bit k-1 set = indxk was out of range last cycle.
- start  out  1  one-cycle pulse that launches a chunker run.
- done  in  1  chunker run complete.
- loaded  out  1  window full.
- count  out  32  valid samples held, saturating at NDATA.

## Operation
- States:
  - LOAD: filling the window.
  - READY: window full.
- Internal registers:
  - `mem[NDATA]`, the sample storage.
  - `wptr`, the physical write pointer, range 0..NDATA-1.
  - `base`, the physical location of logical index 0.
  - `busy`, high while a chunker run is in progress.
- Write acceptance:
  - wr_ready = Rst & !clear & (state==LOAD | (state==READY & SLIDE & !busy & !start)).
  - A sample is accepted when wr_valid & wr_ready.
- LOAD behaviour:
  - An accepted sample is written to mem[wptr]; wptr and count each increment by 1.
  - The sample that makes count reach NDATA moves the state to READY.
  - That transition pulses `start` in the following cycle and sets `busy`.
- READY behaviour (SLIDE=1):
  - An accepted sample is written to mem[base], overwriting the oldest sample.
  - base advances by 1 and wraps from NDATA-1 to 0; count stays at NDATA.
  - The next cycle pulses `start` and sets `busy`.
- READY with SLIDE=0: wr_ready stays 0. `start` fires only once per load.
- `done` clears `busy`. `done` has no effect while busy=0.
  - If `done` and a start-setting event occur in the same cycle, busy ends at 1.
- Read address mapping:
  - phys = base + indx; if phys ≥ NDATA, subtract NDATA.
  - In LOAD, base = 0, so phys = indx.
- Read response:
  - A read whose indx < count returns value = mem[phys] and rd_err bit = 0.
  - A read whose indx ≥ count, including indx ≥ NDATA, returns value = 0 and rd_err bit = 1.
  - The four ports are fully independent and may use the same index.
- Read/write collision: a read of the location being written in the same cycle returns the old data (read-before-write).
- clear behaviour:
  - clear has priority over everything else; any sample offered in that cycle is not accepted, since wr_ready = 0.
  - Next cycle: state = LOAD, count = 0, wptr = 0, base = 0, busy = 0, loaded = 0.
  - mem contents are left unchanged but are unreadable, because count = 0.
- A `done` pulse arriving after `clear` is ignored.
- loaded = (state==READY).

## Timing
- Reset values (cycle after Rst sampled low):
  - State and counters: state LOAD, count 0, wptr 0, base 0, busy 0.
  - Control outputs: loaded 0, start 0, rd_err 0.
  - Read data: value1..4 = 0.
- wr_ready is 0 while Rst is low and is 1 in the first cycle after reset.
- Read latency is 1 cycle: indx presented at edge t gives value/rd_err valid after edge t+1. Reads are pipelined, one per port per cycle.
- Write acceptance at edge t updates count and mem at edge t; readable by an index presented in cycle t+1.
- The NDATA-th accepted sample at edge t gives: loaded = 1 after edge t, start high during cycle t+1 only, busy = 1 after edge t+1.
- wr_ready drops in cycle t+1, because `start` is high, and stays 0 until the cycle after `done` is sampled.
- Minimum sliding cadence: one sample per (chunker run + 2) cycles.
- Reset mid-run: the block returns to the reset state; no `start` is issued; a pending `done` is ignored.

## Test plan
- Fill, NDATA=20: stream samples 100..119 back-to-back.
  - wr_ready stays 1 throughout; loaded rises after sample 20.
  - start pulses exactly once, one cycle later; wr_ready = 0 until `done`.
- Parallel read: after the fill, present indx1..4 = 0, 5, 19, 19.
  - Next cycle: value = 100, 105, 119, 119; rd_err = 0000.
- Out of range: after 3 samples (10, 11, 12), present indx = 2, 3, 20, 0xFFFFFFFF.
  - Values = 12, 0, 0, 0; rd_err = 1110.
- Slide and wrap, SLIDE=1: after the fill, issue `done`, then write 200, then issue `done` and write 201.
  - indx 0 reads 102, indx 18 reads 200, indx 19 reads 201; start has pulsed 3 times in total.
  - Repeat 20 slides: base returns to 0.
- Simultaneous events:
  - clear with wr_valid in the same cycle: the sample is dropped and count = 0.
  - done in the same cycle as a start-setting write: busy remains 1 and wr_ready = 0.
  - A read of a slot being overwritten returns the old sample.
- Reset mid-run: assert Rst low for one cycle while busy.
  - All outputs return to reset values; a later `done` produces no `start`; a refill behaves identically to the first fill.
